scemi_out_pipe_proxy: RTL
=========================

SCEMI_OUT_PIPE_PROXY -- requirements
Module: scemi_out_pipe_proxy

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the payload width in bits (at least 1).
REQ-002 SHALL have parameter DEPTH, default 4, the buffer depth in words (a power of 2, at least 2).
REQ-003 SHALL have parameter PORT_ID, default 16'd0, the 16-bit identifier presented during binding.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port BIND_REQ, output, 1 bit: bind request to the host link.
REQ-007 SHALL have port BIND_ID, output, 16 bits: constant PORT_ID.
REQ-008 SHALL have port BIND_ACK, input, 1 bit: host bind response strobe.
REQ-009 SHALL have port BIND_OK, input, 1 bit: bind success, qualified by BIND_ACK.
REQ-010 SHALL have port BIND_INDEX, input, 32 bits: proxy index, qualified by BIND_ACK and BIND_OK.
REQ-011 SHALL have port HOST_VALID, input, 1 bit: host word valid.
REQ-012 SHALL have port HOST_DATA, input, WIDTH bits: host word.
REQ-013 SHALL have port HOST_READY, output, 1 bit: proxy can accept a host word.
REQ-014 SHALL have port PROXY_INDEX, output, 32 bits: latched bind index.
REQ-015 SHALL have port DATA, output, WIDTH bits: head-of-buffer word.
REQ-016 SHALL have port DATA_RDY, output, 1 bit: buffer non-empty.
REQ-017 SHALL have port DATA_EN, input, 1 bit: consumer dequeue strobe.
REQ-018 SHALL have port COUNT, output, $clog2(DEPTH)+1 bits: buffer occupancy.
REQ-019 SHALL have port BOUND, output, 1 bit: state is ACTIVE.
REQ-020 SHALL have port FAIL, output, 1 bit: state is FAILED.
REQ-021 SHALL have port UNDERFLOW, output, 1 bit: sticky flag, DATA_EN was seen while the buffer was empty.

Function
REQ-022 SHALL implement FSM states IDLE, BINDING, ACTIVE and FAILED.
REQ-023 SHALL transition IDLE -> BINDING unconditionally on the first clock after reset deasserts.
REQ-024 SHALL hold BIND_REQ=1 only in BINDING.
REQ-025 SHALL, in BINDING with BIND_ACK=1 and BIND_OK=1, latch BIND_INDEX into PROXY_INDEX and go to ACTIVE.
REQ-026 SHALL, in BINDING with BIND_ACK=1 and BIND_OK=0, go to FAILED; PROXY_INDEX is unchanged.
REQ-027 SHALL ignore BIND_ACK in IDLE, ACTIVE and FAILED.
REQ-028 SHALL treat ACTIVE and FAILED as terminal until reset.
REQ-029 SHALL drive HOST_READY = (state==ACTIVE) && (COUNT<DEPTH), computed from registered state only.
REQ-030 SHALL write HOST_DATA into the buffer when HOST_VALID && HOST_READY (a transfer).
REQ-031 SHALL drop nothing silently: HOST_VALID while HOST_READY=0 is held off by the host, not stored.
REQ-032 SHALL drive DATA and DATA_RDY from registered buffer state, with DATA_RDY = (COUNT!=0).
REQ-033 SHALL make a word accepted in cycle N visible on DATA with DATA_RDY=1 in cycle N+1 (no bypass path).
REQ-034 SHALL dequeue the head word when DATA_EN && DATA_RDY.
REQ-035 SHALL keep DATA stable until dequeued.
REQ-036 SHALL, on DATA_EN while DATA_RDY=0, perform no dequeue and set UNDERFLOW to 1.
REQ-037 SHALL, on a simultaneous transfer and dequeue, leave COUNT unchanged and keep FIFO order.
REQ-038 SHALL make full simultaneous enqueue and dequeue impossible by construction, since HOST_READY=0 when COUNT==DEPTH.
REQ-039 SHALL wrap the read and write pointers modulo DEPTH.
REQ-040 SHALL maintain COUNT in the range 0..DEPTH.
REQ-041 SHALL preserve FIFO order across pointer wrap.
REQ-042 SHALL allow the consumer to drain buffered words in any state.
REQ-043 SHALL block new transfers outside ACTIVE.

Reset
REQ-044 SHALL, when RST_N=1 at a rising CLK, reset state to IDLE.
REQ-045 SHALL, on reset, clear both pointers, COUNT=0, PROXY_INDEX=0 and UNDERFLOW=0.
REQ-046 SHALL hold all outputs at these values during reset: BIND_REQ=0, HOST_READY=0, DATA_RDY=0, BOUND=0, FAIL=0.
REQ-047 SHALL leave buffer storage contents unreset, with DATA undefined while DATA_RDY=0.
REQ-048 SHALL, on reset mid-operation, discard buffered words and abandon a pending bind; the post-reset bind restarts from IDLE.

Verification
REQ-049 SHALL cover: reset, then BIND_ACK=1, BIND_OK=1, BIND_INDEX=32'h35 in cycle 3 -> BOUND=1 and PROXY_INDEX=32'h35 from cycle 4; BIND_REQ=1 only in cycles 1..3.
REQ-050 SHALL cover: BIND_ACK=1 with BIND_OK=0 -> FAIL=1 permanently, HOST_READY=0, PROXY_INDEX=0, a later BIND_ACK ignored.
REQ-051 SHALL cover: DEPTH=4, bound, host streams 1..6 with DATA_EN=0 -> accepts 1..4, HOST_READY=0 at COUNT=4; then DATA_EN=1 continuously -> DATA 1,2,3,4,5,6 in order across pointer wrap.
REQ-052 SHALL cover: COUNT=2, a transfer and a dequeue in the same cycle -> COUNT stays 2 and the next DATA is the old second word.
REQ-053 SHALL cover: empty buffer with DATA_EN=1 -> UNDERFLOW=1 sticky, COUNT stays 0; cleared only by reset.
REQ-054 SHALL cover: RST_N=1 asserted with COUNT=3 -> next cycle COUNT=0, DATA_RDY=0, state IDLE, then BIND_REQ=1 again.

Source files
------------

// File: rtl/scemi_out_pipe_proxy.sv
// Output-pipe proxy: binds to the host link once after reset, then buffers
// host words in a DEPTH-entry FIFO that the consumer drains.
module scemi_out_pipe_proxy #(
  parameter int          WIDTH   = 32,
  parameter int          DEPTH   = 4,
  parameter logic [15:0] PORT_ID = 16'd0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  output logic                       BIND_REQ,
  output logic [15:0]                BIND_ID,
  input  logic                       BIND_ACK,
  input  logic                       BIND_OK,
  input  logic [31:0]                BIND_INDEX,
  input  logic                       HOST_VALID,
  input  logic [WIDTH-1:0]           HOST_DATA,
  output logic                       HOST_READY,
  output logic [31:0]                PROXY_INDEX,
  output logic [WIDTH-1:0]           DATA,
  output logic                       DATA_RDY,
  input  logic                       DATA_EN,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       BOUND,
  output logic                       FAIL,
  output logic                       UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BINDING = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_FAILED  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              index_load_s;
  logic [31:0]       proxy_index_r;
  logic              underflow_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_nxt_s;
  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic              host_ready_s;
  logic              data_rdy_s;
  logic              push_s;
  logic              pop_s;

  // Handshake qualifiers, all derived from registered state only
  assign host_ready_s = (state_r == ST_ACTIVE) && (count_r < DEPTH_C);
  assign data_rdy_s   = (count_r != {CW{1'b0}});
  assign push_s       = HOST_VALID && host_ready_s;
  assign pop_s        = DATA_EN && data_rdy_s;

  // Bind sequencing; ACTIVE and FAILED only leave through reset
  always_comb begin
    state_nxt_s  = state_r;
    index_load_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_BINDING;
      end
      ST_BINDING: begin
        if (BIND_ACK) begin
          if (BIND_OK) begin
            state_nxt_s  = ST_ACTIVE;
            index_load_s = 1'b1;
          end else begin
            state_nxt_s = ST_FAILED;
          end
        end else begin
          state_nxt_s = ST_BINDING;
        end
      end
      ST_ACTIVE: state_nxt_s = ST_ACTIVE;
      ST_FAILED: state_nxt_s = ST_FAILED;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Occupancy update; a simultaneous push and pop leaves it unchanged
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Control state register with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      state_r       <= ST_IDLE;
      proxy_index_r <= 32'd0;
      underflow_r   <= 1'b0;
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
      if (index_load_s) begin
        proxy_index_r <= BIND_INDEX;
      end
      if (DATA_EN && !data_rdy_s) begin
        underflow_r <= 1'b1;
      end
      // Pointers wrap naturally since DEPTH is a power of two
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

  // Buffer storage, deliberately left unreset
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= HOST_DATA;
    end
  end

  assign BIND_REQ    = (state_r == ST_BINDING);
  assign BIND_ID     = PORT_ID;
  assign HOST_READY  = host_ready_s;
  assign PROXY_INDEX = proxy_index_r;
  assign DATA        = mem_r[rd_ptr_r];
  assign DATA_RDY    = data_rdy_s;
  assign COUNT       = count_r;
  assign BOUND       = (state_r == ST_ACTIVE);
  assign FAIL        = (state_r == ST_FAILED);
  assign UNDERFLOW   = underflow_r;

endmodule
